// File: rtl/digit_scan_capture_pkg.sv
// Shared constants, field indices and FSM encoding for the digit scan/capture block.
package digit_scan_capture_pkg;

    localparam int unsigned N_FIELDS = 9;
    localparam int unsigned SEL_W    = 4;

    // Field indices as driven on sel_o
    localparam logic [SEL_W-1:0] FLD_DATE  = 4'd0;
    localparam logic [SEL_W-1:0] FLD_MONTH = 4'd1;
    localparam logic [SEL_W-1:0] FLD_YEAR  = 4'd2;
    localparam logic [SEL_W-1:0] FLD_HR    = 4'd3;
    localparam logic [SEL_W-1:0] FLD_MIN   = 4'd4;
    localparam logic [SEL_W-1:0] FLD_SEC   = 4'd5;
    localparam logic [SEL_W-1:0] FLD_THR   = 4'd6;
    localparam logic [SEL_W-1:0] FLD_TMIN  = 4'd7;
    localparam logic [SEL_W-1:0] FLD_TSEG  = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StSwap
    } scan_state_e;

    // A nibble outside 0..9 is not a valid BCD digit
    function automatic logic bcd_bad(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/digit_scan_capture_bank.sv
// Double-buffered digit store: writes land in the shadow bank, reads come from the
// visible bank through a registered port, swap flips which bank is visible.
module digit_bank
    import digit_scan_capture_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [SEL_W-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             swap_i,
    input  logic [SEL_W-1:0] rd_addr_i,
    output logic [7:0]       rd_data_o
);

    localparam logic [SEL_W-1:0] LAST_ADDR = SEL_W'(N_FIELDS - 1);

    logic       bank_q;                   // index of the visible bank
    logic [7:0] mem_q [2][N_FIELDS];
    logic [7:0] rd_q;

    // Storage and bank pointer; shadow bank is always the one not being read
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int f = 0; f < int'(N_FIELDS); f++) begin
                    mem_q[b][f] <= 8'h00;
                end
            end
        end else begin
            if (wr_en_i && (wr_addr_i <= LAST_ADDR)) begin
                mem_q[~bank_q][wr_addr_i] <= wr_data_i;
            end
            if (swap_i) begin
                bank_q <= ~bank_q;
            end
        end
    end

    // Registered read of the visible bank; out-of-range addresses read as zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q <= 8'h00;
        end else if (rd_addr_i <= LAST_ADDR) begin
            rd_q <= mem_q[bank_q][rd_addr_i];
        end else begin
            rd_q <= 8'h00;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/digit_scan_capture.sv
// Sweeps the upstream field-select mux over all fields, waits for the splitter
// outputs to settle, captures both digits into the shadow bank and swaps banks
// at the end of each complete sweep.
module digit_scan_capture
    import digit_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             scan_tick_i,
    input  logic [3:0]       dec_i,
    input  logic [3:0]       uni_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             bcd_err_o,
    input  logic [SEL_W-1:0] rd_addr_i,
    output logic [3:0]       rd_dec_o,
    output logic [3:0]       rd_uni_o
);

    localparam int unsigned     CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_FIELDS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             acc_q, acc_d;     // error seen in the sweep in progress
    logic             err_q, err_d;     // error flag of the last completed sweep
    logic             wr_en;
    logic             swap;
    logic [7:0]       rd_data;

    // State, counters and error flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic for the sweep sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        acc_d   = acc_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        swap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (scan_tick_i) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                wr_en = 1'b1;
                if (bcd_bad(dec_i) || bcd_bad(uni_i)) begin
                    acc_d = 1'b1;
                end
                if (sel_q == SEL_LAST) begin
                    state_d = StSwap;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSwap: begin
                swap    = 1'b1;
                err_d   = acc_q;
                sel_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    digit_bank u_bank (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (sel_q),
        .wr_data_i ({dec_i, uni_i}),
        .swap_i    (swap),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data)
    );

    assign sel_o        = sel_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = (state_q == StSwap);
    assign bcd_err_o    = err_q;
    assign rd_dec_o     = rd_data[7:4];
    assign rd_uni_o     = rd_data[3:0];

endmodule

// File: tb/tb_digit_scan_capture.sv
// Directed bench for digit_scan_capture with a simple upstream mux/splitter model.
module tb_digit_scan_capture;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       scan_tick_i;
    logic [3:0] dec_i;
    logic [3:0] uni_i;
    logic [3:0] sel_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       bcd_err_o;
    logic [3:0] rd_addr_i;
    logic [3:0] rd_dec_o;
    logic [3:0] rd_uni_o;

    int checks = 0;
    int errors = 0;

    // Upstream model: normally dec=sel, uni=9-sel; alt swaps them; err_en corrupts field 6
    logic alt    = 1'b0;
    logic err_en = 1'b0;

    assign dec_i = alt ? 4'(4'd9 - sel_o) : sel_o;
    assign uni_i = (err_en && sel_o == 4'd6) ? 4'hA : (alt ? sel_o : 4'(4'd9 - sel_o));

    always #5 clk_i = ~clk_i;

    digit_scan_capture dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .scan_tick_i  (scan_tick_i),
        .dec_i        (dec_i),
        .uni_i        (uni_i),
        .sel_o        (sel_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .bcd_err_o    (bcd_err_o),
        .rd_addr_i    (rd_addr_i),
        .rd_dec_o     (rd_dec_o),
        .rd_uni_o     (rd_uni_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Tick at edge 0, return in cycle 29 (first IDLE cycle after SWAP)
    task automatic run_sweep();
        scan_tick_i = 1'b1;
        cyc();
        scan_tick_i = 1'b0;
        repeat (28) cyc();
    endtask

    task automatic test_reset();
        rst_n_i     = 1'b0;
        scan_tick_i = 1'b0;
        rd_addr_i   = 4'd0;
        #2;
        checks++;
        if ({sel_o, busy_o, frame_done_o, bcd_err_o, rd_dec_o, rd_uni_o} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d busy=%0b fd=%0b err=%0b rd=%h%h, want all 0",
                     sel_o, busy_o, frame_done_o, bcd_err_o, rd_dec_o, rd_uni_o);
        end
        #10;
        rst_n_i = 1'b1;
        for (int f = 0; f < 9; f++) begin
            rd_addr_i = 4'(f);
            cyc();
            checks++;
            if (rd_dec_o !== 4'd0 || rd_uni_o !== 4'd0) begin
                errors++;
                $display("FAIL reset_read f%0d: got %h,%h want 0,0", f, rd_dec_o, rd_uni_o);
            end
        end
        checks++;
        if (sel_o !== 4'd0 || bcd_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got sel=%0d err=%0b busy=%0b want 0,0,0",
                     sel_o, bcd_err_o, busy_o);
        end
    endtask

    task automatic test_sweep();
        rd_addr_i   = 4'd2;
        scan_tick_i = 1'b1;
        cyc();
        scan_tick_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if (frame_done_o !== (c == 28)) begin
                errors++;
                $display("FAIL sweep_frame_done c%0d: got %0b want %0b", c, frame_done_o, c == 28);
            end
            checks++;
            if (busy_o !== (c <= 28)) begin
                errors++;
                $display("FAIL sweep_busy c%0d: got %0b want %0b", c, busy_o, c <= 28);
            end
            if (c <= 27) begin
                checks++;
                if (sel_o !== 4'((c - 1) / 3)) begin
                    errors++;
                    $display("FAIL sweep_sel c%0d: got %0d want %0d", c, sel_o, (c - 1) / 3);
                end
            end else if (c >= 29) begin
                checks++;
                if (sel_o !== 4'd0) begin
                    errors++;
                    $display("FAIL sweep_sel_idle c%0d: got %0d want 0", c, sel_o);
                end
            end
            checks++;
            if (rd_dec_o !== ((c >= 30) ? 4'd2 : 4'd0) || rd_uni_o !== ((c >= 30) ? 4'd7 : 4'd0)) begin
                errors++;
                $display("FAIL sweep_rd2 c%0d: got %h,%h", c, rd_dec_o, rd_uni_o);
            end
            if (c < 30) cyc();
        end
        checks++;
        if (bcd_err_o !== 1'b0) begin
            errors++;
            $display("FAIL sweep_bcd_err: got %0b want 0", bcd_err_o);
        end
        for (int f = 0; f < 9; f++) begin
            rd_addr_i = 4'(f);
            cyc();
            checks++;
            if (rd_dec_o !== 4'(f) || rd_uni_o !== 4'(9 - f)) begin
                errors++;
                $display("FAIL sweep_read f%0d: got %h,%h want %0d,%0d", f, rd_dec_o, rd_uni_o,
                         f, 9 - f);
            end
        end
        rd_addr_i = 4'd12;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd0 || rd_uni_o !== 4'd0) begin
            errors++;
            $display("FAIL sweep_read_oob: got %h,%h want 0,0", rd_dec_o, rd_uni_o);
        end
    endtask

    task automatic test_bcd_err();
        err_en = 1'b1;
        run_sweep();
        checks++;
        if (bcd_err_o !== 1'b1) begin
            errors++;
            $display("FAIL bcd_err_set: got %0b want 1", bcd_err_o);
        end
        rd_addr_i = 4'd6;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd6 || rd_uni_o !== 4'hA) begin
            errors++;
            $display("FAIL bcd_err_f6: got %h,%h want 6,a", rd_dec_o, rd_uni_o);
        end
        rd_addr_i = 4'd5;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd5 || rd_uni_o !== 4'd4) begin
            errors++;
            $display("FAIL bcd_err_f5: got %h,%h want 5,4", rd_dec_o, rd_uni_o);
        end
        err_en = 1'b0;
        run_sweep();
        checks++;
        if (bcd_err_o !== 1'b0) begin
            errors++;
            $display("FAIL bcd_err_clear: got %0b want 0", bcd_err_o);
        end
        rd_addr_i = 4'd6;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd6 || rd_uni_o !== 4'd3) begin
            errors++;
            $display("FAIL bcd_err_f6_clean: got %h,%h want 6,3", rd_dec_o, rd_uni_o);
        end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int pos[3] = '{0, 0, 0};
        int sel_bad = 0;
        bit idle_seen = 1'b0;
        scan_tick_i = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            cyc();
            if (frame_done_o) begin
                if (n_done < 3) pos[n_done] = c;
                n_done++;
            end
            if (sel_o > 4'd8) sel_bad++;
        end
        scan_tick_i = 1'b0;
        checks++;
        if (n_done !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d frames want 3", n_done);
        end
        checks++;
        if (pos[0] !== 28 || pos[1] !== 57 || pos[2] !== 86) begin
            errors++;
            $display("FAIL b2b_positions: got %0d,%0d,%0d want 28,57,86", pos[0], pos[1], pos[2]);
        end
        checks++;
        if (sel_bad !== 0) begin
            errors++;
            $display("FAIL b2b_sel_range: got %0d cycles with sel>8 want 0", sel_bad);
        end
        // A fourth sweep was accepted at edge 87; let it finish
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            cyc();
            if (!busy_o) idle_seen = 1'b1;
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("FAIL b2b_idle_timeout: busy still %0b want 0", busy_o);
        end
    endtask

    task automatic test_swap_visibility();
        alt         = 1'b1;
        rd_addr_i   = 4'd2;
        scan_tick_i = 1'b1;
        cyc();
        scan_tick_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if (rd_dec_o !== ((c >= 30) ? 4'd7 : 4'd2) || rd_uni_o !== ((c >= 30) ? 4'd2 : 4'd7)) begin
                errors++;
                $display("FAIL swap_rd2 c%0d: got %h,%h", c, rd_dec_o, rd_uni_o);
            end
            if (c == 28) begin
                checks++;
                if (frame_done_o !== 1'b1) begin
                    errors++;
                    $display("FAIL swap_frame_done: got %0b want 1", frame_done_o);
                end
            end
            if (c < 30) cyc();
        end
        rd_addr_i = 4'd12;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd0 || rd_uni_o !== 4'd0) begin
            errors++;
            $display("FAIL swap_read_oob: got %h,%h want 0,0", rd_dec_o, rd_uni_o);
        end
        alt = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        bit fd_seen = 1'b0;
        rd_addr_i   = 4'd2;
        scan_tick_i = 1'b1;
        cyc();
        scan_tick_i = 1'b0;
        repeat (14) cyc();
        checks++;
        if (sel_o !== 4'd4 || rd_dec_o !== 4'd7) begin
            errors++;
            $display("FAIL midsweep_pre: got sel=%0d rd_dec=%h want 4,7", sel_o, rd_dec_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({sel_o, busy_o, frame_done_o, bcd_err_o, rd_dec_o, rd_uni_o} !== 15'd0) begin
            errors++;
            $display("FAIL midsweep_reset: got sel=%0d busy=%0b fd=%0b err=%0b rd=%h%h, want all 0",
                     sel_o, busy_o, frame_done_o, bcd_err_o, rd_dec_o, rd_uni_o);
        end
        repeat (2) cyc();
        rst_n_i = 1'b1;
        cyc();
        checks++;
        if (rd_dec_o !== 4'd0 || rd_uni_o !== 4'd0) begin
            errors++;
            $display("FAIL midsweep_read2: got %h,%h want 0,0", rd_dec_o, rd_uni_o);
        end
        rd_addr_i = 4'd3;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (frame_done_o || busy_o) fd_seen = 1'b1;
        end
        checks++;
        if (fd_seen) begin
            errors++;
            $display("FAIL midsweep_no_frame: frame_done/busy seen after reset, want none");
        end
        checks++;
        if (rd_dec_o !== 4'd0 || rd_uni_o !== 4'd0) begin
            errors++;
            $display("FAIL midsweep_read3: got %h,%h want 0,0", rd_dec_o, rd_uni_o);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_bcd_err();
        test_back_to_back();
        test_swap_visibility();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
